// File: rtl/match_sequencer_if.sv
// ---------------------------------------------------------------------------
// match_sequencer_if
//
// Bundles the per-frame inputs and the game-state outputs of the Pong
// match sequencer.
//
//   master modport (game/key logic side, also the bench):
//     frame_tick  out  one-cycle pulse per video frame
//     start       out  one-pulsed Enter key
//     ball_x      out  current ball X position (top-left), 10 bits
//     pause       out  one-pulsed pause key (only with MATCH_PAUSE_EN)
//     state       in   0=IDLE 1=SERVE 2=PLAY 3=OVER
//     score1      in   player 1 score
//     score2      in   player 2 score
//     ball_rst    in   one-cycle pulse: re-centre the ball
//     serve_dir   in   0=serve toward player 1 (left), 1=toward player 2
//     winner      in   valid in OVER: 0=player 1, 1=player 2
//   slave modport (match_sequencer side): same signals, opposite direction.
//
// Optional feature macro: MATCH_PAUSE_EN (adds the pause signal).
// ---------------------------------------------------------------------------
interface match_sequencer_if #(
  parameter int SCORE_W = 2
);
  logic               frame_tick;
  logic               start;
  logic [9:0]         ball_x;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               ball_rst;
  logic               serve_dir;
  logic               winner;
`ifdef MATCH_PAUSE_EN
  logic               pause;

  modport master (
    output frame_tick, start, ball_x, pause,
    input  state, score1, score2, ball_rst, serve_dir, winner
  );
  modport slave (
    input  frame_tick, start, ball_x, pause,
    output state, score1, score2, ball_rst, serve_dir, winner
  );
`else
  modport master (
    output frame_tick, start, ball_x,
    input  state, score1, score2, ball_rst, serve_dir, winner
  );
  modport slave (
    input  frame_tick, start, ball_x,
    output state, score1, score2, ball_rst, serve_dir, winner
  );
`endif
endinterface

// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// match_sequencer
//
// Rally/score sequencer for the Pong datapath. Counts frames during the
// serve countdown, detects misses at the field limits while in play,
// keeps both scores and reports the game-state code used by the ball,
// paddle and pixel-generation blocks.
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active-high, highest priority
//   bus   match_sequencer_if.slave (frame_tick, start, ball_x, [pause] in;
//         state, score1, score2, ball_rst, serve_dir, winner out)
//
// Optional feature macro: MATCH_PAUSE_EN
//   When defined, a pause pulse in SERVE or PLAY toggles a freeze flag.
//   While frozen the state output reads SERVE, the frame counter holds and
//   no miss detection occurs; the next pause resumes where it left off.
// ---------------------------------------------------------------------------
module match_sequencer #(
  parameter int         SCORE_W      = 2,
  parameter int         WIN_SCORE    = 3,
  parameter int         SERVE_FRAMES = 60,
  parameter logic [9:0] LEFT_LIMIT   = 10'd4,
  parameter logic [9:0] RIGHT_LIMIT  = 10'd620
) (
  input  logic              clk,
  input  logic              rst,
  match_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_Q    = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               ball_rst_q, ball_rst_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               freeze_q, freeze_d;
  logic               pause_pulse;

`ifdef MATCH_PAUSE_EN
  assign pause_pulse = bus.pause;
`else
  assign pause_pulse = 1'b0;
`endif

  // Post-point score values, used for the match-end test.
  logic [SCORE_W-1:0] score1_inc, score2_inc;
  assign score1_inc = score1_q + 1'b1;
  assign score2_inc = score2_q + 1'b1;

  // A frame counts only when not frozen; freeze is always 0 without pause.
  logic tick_live;
  assign tick_live = bus.frame_tick & ~freeze_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score1_q    <= '0;
      score2_q    <= '0;
      ball_rst_q  <= 1'b0;
      serve_dir_q <= 1'b1;
      winner_q    <= 1'b0;
      cnt_q       <= '0;
      freeze_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      ball_rst_q  <= ball_rst_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      cnt_q       <= cnt_d;
      freeze_q    <= freeze_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    ball_rst_d  = 1'b0;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    freeze_d    = freeze_q;

    unique case (state_q)
      ST_IDLE: begin
        score1_d = '0;
        score2_d = '0;
        if (bus.start) begin
          state_d    = ST_SERVE;
          ball_rst_d = 1'b1;
          cnt_d      = '0;
        end
      end

      ST_SERVE: begin
        if (pause_pulse) freeze_d = ~freeze_q;
        if (tick_live) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (pause_pulse) freeze_d = ~freeze_q;
        // Left test first so that overlapping limits favour the left miss.
        if (tick_live && (bus.ball_x <= LEFT_LIMIT)) begin
          score2_d    = score2_inc;
          serve_dir_d = 1'b0;
          if (score2_inc == WIN_Q) begin
            state_d  = ST_OVER;
            winner_d = 1'b1;
          end else begin
            state_d    = ST_SERVE;
            ball_rst_d = 1'b1;
            cnt_d      = '0;
          end
        end else if (tick_live && (bus.ball_x >= RIGHT_LIMIT)) begin
          score1_d    = score1_inc;
          serve_dir_d = 1'b1;
          if (score1_inc == WIN_Q) begin
            state_d  = ST_OVER;
            winner_d = 1'b0;
          end else begin
            state_d    = ST_SERVE;
            ball_rst_d = 1'b1;
            cnt_d      = '0;
          end
        end
      end

      ST_OVER: begin
        if (bus.start) begin
          state_d  = ST_IDLE;
          score1_d = '0;
          score2_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_OVER || state_d == ST_IDLE) freeze_d = 1'b0;
  end

  // Frozen play/serve is presented as SERVE so ball and paddles stand still.
  assign bus.state     = freeze_q ? ST_SERVE : state_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.ball_rst  = ball_rst_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// ---------------------------------------------------------------------------
// tb_match_sequencer
//
// Scoreboard bench for match_sequencer: each driven cycle pushes the
// expected outputs (from a small behavioural game model) into a queue,
// which is popped and compared one cycle later. A few directly stated
// expectations from the game rules are checked as well.
// Define MATCH_PAUSE_EN to include the pause scenario.
// ---------------------------------------------------------------------------
module tb_match_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  match_sequencer_if #(.SCORE_W(2)) bus ();

  match_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] state;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       brst;
    logic       dir;
    logic       win;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference game model.
  int m_state, m_s1, m_s2, m_cnt;
  bit m_brst, m_dir, m_win, m_frz;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit ft, input bit st,
                       input int x, input bit p);
    if (r) begin
      m_state = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
      m_brst = 0; m_dir = 1; m_win = 0; m_frz = 0;
      return;
    end
    m_brst = 0;
    case (m_state)
      0: begin
        m_s1 = 0; m_s2 = 0;
        if (st) begin m_state = 1; m_brst = 1; m_cnt = 0; end
      end
      1: begin
        if (ft && !m_frz) begin
          if (m_cnt == 59) begin m_state = 2; m_cnt = 0; end
          else m_cnt++;
        end
        if (p) m_frz = !m_frz;
      end
      2: begin
        if (ft && !m_frz && x <= 4) begin
          m_s2++; m_dir = 0;
          if (m_s2 == 3) begin m_state = 3; m_win = 1; end
          else begin m_state = 1; m_brst = 1; m_cnt = 0; end
        end else if (ft && !m_frz && x >= 620) begin
          m_s1++; m_dir = 1;
          if (m_s1 == 3) begin m_state = 3; m_win = 0; end
          else begin m_state = 1; m_brst = 1; m_cnt = 0; end
        end
        if (p) m_frz = !m_frz;
      end
      default: begin
        if (st) begin m_state = 0; m_s1 = 0; m_s2 = 0; end
      end
    endcase
    if (m_state == 0 || m_state == 3) m_frz = 0;
  endtask

  // One clock of stimulus: drive, predict, clock, pop and compare.
  task automatic step(input string tag, input bit r, input bit ft,
                      input bit st, input int x, input bit p = 1'b0);
    exp_t e, g;
    rst            = r;
    bus.frame_tick = ft;
    bus.start      = st;
    bus.ball_x     = 10'(x);
`ifdef MATCH_PAUSE_EN
    bus.pause      = p;
`endif
    model(r, ft, st, x, p);
    e.tag = tag; e.state = 2'(m_frz ? 1 : m_state);
    e.s1 = 2'(m_s1); e.s2 = 2'(m_s2);
    e.brst = m_brst; e.dir = m_dir; e.win = m_win;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check({g.tag, ".state"},     bus.state,     g.state);
    check({g.tag, ".score1"},    bus.score1,    g.s1);
    check({g.tag, ".score2"},    bus.score2,    g.s2);
    check({g.tag, ".ball_rst"},  bus.ball_rst,  g.brst);
    check({g.tag, ".serve_dir"}, bus.serve_dir, g.dir);
    if (g.state == 2'd3) check({g.tag, ".winner"}, bus.winner, g.win);
    $display("[%0t] %-10s st=%0d s1=%0d s2=%0d brst=%0b dir=%0b win=%0b",
             $time, g.tag, bus.state, bus.score1, bus.score2,
             bus.ball_rst, bus.serve_dir, bus.winner);
  endtask

  // n frame ticks, each followed by one quiet cycle.
  task automatic ticks(input string tag, input int n, input int x);
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 1, 0, x);
      step(tag, 0, 0, 0, x);
    end
  endtask

  // Watchdog: the sequence is fixed-length, this only guards a hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.ball_x = 10'd320;
`ifdef MATCH_PAUSE_EN
    bus.pause = 1'b0;
`endif
    model(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    step("reset", 1, 0, 0, 320);
    check("rst_state", bus.state, 0);
    check("rst_dir", bus.serve_dir, 1);
    step("idle", 0, 1, 0, 3);

    // Serve countdown with start and misses ignored while serving.
    step("start", 0, 0, 1, 320);
    check("start_brst", bus.ball_rst, 1);
    check("start_state", bus.state, 1);
    step("brst_off", 0, 0, 1, 3);
    check("brst_once", bus.ball_rst, 0);
    ticks("serve", 59, 3);
    check("serve59", bus.state, 1);
    step("serve60", 0, 1, 0, 320);
    check("serve60", bus.state, 2);

    // Left miss needs a frame tick.
    repeat (3) step("hold_x3", 0, 0, 0, 3);
    check("hold_score2", bus.score2, 0);
    step("left_miss", 0, 1, 0, 3);
    check("lm_score2", bus.score2, 1);
    check("lm_dir", bus.serve_dir, 0);
    check("lm_brst", bus.ball_rst, 1);
    step("lm_after", 0, 0, 0, 3);
    check("lm_brst_off", bus.ball_rst, 0);

    // Right boundary: 619 is in, 620 is a miss.
    ticks("serve", 60, 320);
    step("x619", 0, 1, 0, 619);
    check("x619_state", bus.state, 2);
    step("x620", 0, 1, 0, 620);
    check("x620_score1", bus.score1, 1);

    // Drive player 1 to the winning score.
    for (int k = 0; k < 2; k++) begin
      ticks("serve", 60, 320);
      step("right_miss", 0, 1, 0, 620);
    end
    check("over_state", bus.state, 3);
    check("over_winner", bus.winner, 0);
    ticks("over_frz", 3, 700);
    check("over_score1", bus.score1, 3);
    step("to_idle", 0, 0, 1, 320);
    check("idle_score1", bus.score1, 0);

    // New match, player 1 reaches 2, then reset mid-play.
    step("start2", 0, 0, 1, 320);
    for (int k = 0; k < 2; k++) begin
      ticks("serve", 60, 320);
      step("right_miss", 0, 1, 0, 700);
    end
    ticks("serve", 60, 320);
    check("pre_rst_s1", bus.score1, 2);
    step("rst_play", 1, 0, 0, 320);
    check("rst_play_st", bus.state, 0);
    check("rst_play_s1", bus.score1, 0);

    // Player 2 wins a match.
    step("start3", 0, 0, 1, 320);
    for (int k = 0; k < 3; k++) begin
      ticks("serve", 60, 320);
      step("left_miss", 0, 1, 0, 0);
    end
    check("p2_winner", bus.winner, 1);

`ifdef MATCH_PAUSE_EN
    step("to_idle", 0, 0, 1, 320);
    step("start4", 0, 0, 1, 320);
    ticks("serve", 30, 320);
    step("pause_on", 0, 0, 0, 320, 1);
    ticks("frozen", 20, 3);
    check("frozen_st", bus.state, 1);
    step("pause_off", 0, 0, 0, 320, 1);
    ticks("serve", 29, 320);
    check("resume29", bus.state, 1);
    step("resume30", 0, 1, 0, 320);
    check("resume30", bus.state, 2);
    step("pause_play", 0, 0, 0, 320, 1);
    check("pp_state", bus.state, 1);
    ticks("frozen", 3, 3);
    check("pp_score2", bus.score2, 0);
    step("unpause", 0, 0, 0, 320, 1);
    check("unpause_st", bus.state, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
